// File: rtl/control_cochera.sv
// control_cochera: shared-barrier access controller for a parking lot.
// Arbitrates one motorised barrier between an entry lane and an exit lane,
// sequences it through IDLE -> RAISE -> OPEN -> LOWER, and tracks occupancy
// from the passage FSM's entrada/salida pulses.
// Optional feature: define COCHERA_ROUND_ROBIN_EN for round-robin arbitration
// on simultaneous requests. The default build gives fixed priority to exit.
module control_cochera #(
  parameter int unsigned CAPACIDAD = 16,
  parameter int unsigned W_CNT     = 5,
  parameter int unsigned T_MAX     = 200,
  parameter int unsigned T_BAJADA  = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pedido_ent,
  input  logic             pedido_sal,
  input  logic             entrada,
  input  logic             salida,
  input  logic             tope,
  output logic             subir,
  output logic             conc_ent,
  output logic             conc_sal,
  output logic [W_CNT-1:0] ocupacion,
  output logic             lleno,
  output logic             err_tope
);

  // Timers only ever hold 0..limit-1, so clog2 of the larger limit suffices.
  localparam int unsigned TLIM = (T_MAX > T_BAJADA) ? T_MAX : T_BAJADA;
  localparam int unsigned TW   = (TLIM > 1) ? $clog2(TLIM) : 1;

  localparam logic [TW-1:0]    TMAX_M1 = TW'(T_MAX - 1);
  localparam logic [TW-1:0]    TBAJ_M1 = TW'(T_BAJADA - 1);
  localparam logic [W_CNT-1:0] CAP     = W_CNT'(CAPACIDAD);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRaise = 2'd1;
  localparam logic [1:0] StOpen  = 2'd2;
  localparam logic [1:0] StLower = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             pend_ent_q, pend_ent_d;
  logic             pend_sal_q, pend_sal_d;
  logic             conc_ent_q, conc_ent_d;
  logic             conc_sal_q, conc_sal_d;
  logic             subir_q, subir_d;
  logic             err_q, err_d;
  logic [W_CNT-1:0] ocup_q, ocup_d;
  logic             lleno_q, lleno_d;
  logic             elig_ent, elig_sal;
  logic             gnt_ent, gnt_sal;

`ifdef COCHERA_ROUND_ROBIN_EN
  logic prio_ent_q, prio_ent_d;

  // Round-robin pointer: after a grant, favour the other lane on the next tie.
  always_comb begin
    prio_ent_d = prio_ent_q;
    if (gnt_ent) begin
      prio_ent_d = 1'b0;
    end else if (gnt_sal) begin
      prio_ent_d = 1'b1;
    end
  end

  // Pointer register; entry wins the first tie after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_ent_q <= 1'b1;
    end else begin
      prio_ent_q <= prio_ent_d;
    end
  end
`endif

  // Entry is held (not dropped) while the lot is full.
  assign elig_ent = pend_ent_q && !lleno_q;
  assign elig_sal = pend_sal_q;

  // Lane arbitration, only meaningful while idle.
  always_comb begin
    gnt_ent = 1'b0;
    gnt_sal = 1'b0;
    if (state_q == StIdle) begin
      if (elig_ent && elig_sal) begin
`ifdef COCHERA_ROUND_ROBIN_EN
        gnt_ent = prio_ent_q;
        gnt_sal = !prio_ent_q;
`else
        gnt_sal = 1'b1;
`endif
      end else if (elig_sal) begin
        gnt_sal = 1'b1;
      end else if (elig_ent) begin
        gnt_ent = 1'b1;
      end
    end
  end

  // Pending latches: a repeat request while set is absorbed; grant clears.
  always_comb begin
    pend_ent_d = pend_ent_q ? !gnt_ent : pedido_ent;
    pend_sal_d = pend_sal_q ? !gnt_sal : pedido_sal;
  end

  // Barrier sequencing and timers.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    conc_ent_d = conc_ent_q;
    conc_sal_d = conc_sal_q;
    err_d      = 1'b0;
    case (state_q)
      StIdle: begin
        timer_d = '0;
        if (gnt_ent || gnt_sal) begin
          state_d    = StRaise;
          conc_ent_d = gnt_ent;
          conc_sal_d = gnt_sal;
        end
      end
      StRaise: begin
        if (tope) begin
          state_d = StOpen;
          timer_d = '0;
        end else if (timer_q == TMAX_M1) begin
          state_d    = StLower;
          timer_d    = '0;
          err_d      = 1'b1;
          conc_ent_d = 1'b0;
          conc_sal_d = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StOpen: begin
        if ((entrada && conc_ent_q) || (salida && conc_sal_q) || (timer_q == TMAX_M1)) begin
          state_d    = StLower;
          timer_d    = '0;
          conc_ent_d = 1'b0;
          conc_sal_d = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        if (timer_q == TBAJ_M1) begin
          state_d = StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
    endcase
    subir_d = (state_d == StRaise) || (state_d == StOpen);
  end

  // Occupancy: saturating up/down count; simultaneous pulses cancel.
  always_comb begin
    ocup_d = ocup_q;
    if (entrada && !salida && (ocup_q < CAP)) begin
      ocup_d = ocup_q + W_CNT'(1);
    end else if (salida && !entrada && (ocup_q != '0)) begin
      ocup_d = ocup_q - W_CNT'(1);
    end
    lleno_d = (ocup_d == CAP);
  end

  // State and registered outputs; reset drops the motor command at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      pend_ent_q <= 1'b0;
      pend_sal_q <= 1'b0;
      conc_ent_q <= 1'b0;
      conc_sal_q <= 1'b0;
      subir_q    <= 1'b0;
      err_q      <= 1'b0;
      ocup_q     <= '0;
      lleno_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pend_ent_q <= pend_ent_d;
      pend_sal_q <= pend_sal_d;
      conc_ent_q <= conc_ent_d;
      conc_sal_q <= conc_sal_d;
      subir_q    <= subir_d;
      err_q      <= err_d;
      ocup_q     <= ocup_d;
      lleno_q    <= lleno_d;
    end
  end

  assign subir     = subir_q;
  assign conc_ent  = conc_ent_q;
  assign conc_sal  = conc_sal_q;
  assign ocupacion = ocup_q;
  assign lleno     = lleno_q;
  assign err_tope  = err_q;

endmodule

// File: tb/tb_control_cochera.sv
// Directed bench for control_cochera: a default instance plus a CAPACIDAD=2
// instance sharing the same stimulus.
module tb_control_cochera;

  logic       clk;
  logic       reset_n;
  logic       pedido_ent, pedido_sal, entrada, salida, tope;
  logic       subir, conc_ent, conc_sal, lleno, err_tope;
  logic [4:0] ocupacion;
  logic       subir2, conc_ent2, conc_sal2, lleno2, err_tope2;
  logic [4:0] ocupacion2;

  int errors = 0;
  int checks = 0;

  control_cochera dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pedido_ent(pedido_ent),
    .pedido_sal(pedido_sal),
    .entrada   (entrada),
    .salida    (salida),
    .tope      (tope),
    .subir     (subir),
    .conc_ent  (conc_ent),
    .conc_sal  (conc_sal),
    .ocupacion (ocupacion),
    .lleno     (lleno),
    .err_tope  (err_tope)
  );

  control_cochera #(.CAPACIDAD(2)) dut2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .pedido_ent(pedido_ent),
    .pedido_sal(pedido_sal),
    .entrada   (entrada),
    .salida    (salida),
    .tope      (tope),
    .subir     (subir2),
    .conc_ent  (conc_ent2),
    .conc_sal  (conc_sal2),
    .ocupacion (ocupacion2),
    .lleno     (lleno2),
    .err_tope  (err_tope2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    pedido_ent = 1'b0;
    pedido_sal = 1'b0;
    entrada    = 1'b0;
    salida     = 1'b0;
    tope       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({subir, conc_ent, conc_sal, lleno, err_tope} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=00000", {subir, conc_ent, conc_sal, lleno, err_tope});
    end
    checks++; if (ocupacion !== 5'd0) begin
      errors++; $display("FAIL reset_ocup got=%0d exp=0", ocupacion);
    end
  endtask

  task automatic test_entry();
    do_reset();
    pedido_ent = 1'b1; step(); pedido_ent = 1'b0;
    checks++; if (subir !== 1'b0) begin
      errors++; $display("FAIL entry_latch subir got=%b exp=0", subir);
    end
    step();
    checks++; if ({subir, conc_ent, conc_sal} !== 3'b110) begin
      errors++; $display("FAIL entry_grant got=%b exp=110", {subir, conc_ent, conc_sal});
    end
    step(); step();
    tope = 1'b1; step();
    checks++; if (subir !== 1'b1) begin
      errors++; $display("FAIL entry_open subir got=%b exp=1", subir);
    end
    entrada = 1'b1; step(); entrada = 1'b0; tope = 1'b0;
    checks++; if ({subir, conc_ent, ocupacion} !== {2'b00, 5'd1}) begin
      errors++; $display("FAIL entry_pass subir=%b conc_ent=%b ocup=%0d exp 0 0 1", subir, conc_ent, ocupacion);
    end
    // New request during LOWER is served only once LOWER has lasted 20 cycles
    pedido_ent = 1'b1; step(); pedido_ent = 1'b0;
    repeat (19) step();
    checks++; if (subir !== 1'b0) begin
      errors++; $display("FAIL entry_lower_len subir got=%b exp=0", subir);
    end
    step();
    checks++; if ({subir, conc_ent} !== 2'b11) begin
      errors++; $display("FAIL entry_idle_regrant got=%b exp=11", {subir, conc_ent});
    end
  endtask

  task automatic enter_car();
    pedido_ent = 1'b1; step(); pedido_ent = 1'b0;
    step();
    tope = 1'b1; step();
    entrada = 1'b1; step(); entrada = 1'b0; tope = 1'b0;
    repeat (20) step();
  endtask

  task automatic test_full_lot();
    do_reset();
    enter_car();
    enter_car();
    checks++; if ({ocupacion2, lleno2} !== {5'd2, 1'b1}) begin
      errors++; $display("FAIL full_count ocup=%0d lleno=%b exp 2 1", ocupacion2, lleno2);
    end
    pedido_ent = 1'b1; step(); pedido_ent = 1'b0;
    repeat (3) step();
    checks++; if (subir2 !== 1'b0) begin
      errors++; $display("FAIL full_block subir got=%b exp=0", subir2);
    end
    pedido_sal = 1'b1; step(); pedido_sal = 1'b0;
    step();
    checks++; if ({subir2, conc_ent2, conc_sal2} !== 3'b101) begin
      errors++; $display("FAIL full_exit_grant got=%b exp=101", {subir2, conc_ent2, conc_sal2});
    end
    tope = 1'b1; step();
    salida = 1'b1; step(); salida = 1'b0; tope = 1'b0;
    checks++; if ({ocupacion2, lleno2, subir2} !== {5'd1, 2'b00}) begin
      errors++; $display("FAIL full_after_exit ocup=%0d lleno=%b subir=%b exp 1 0 0", ocupacion2, lleno2, subir2);
    end
    repeat (20) step();
    checks++; if (subir2 !== 1'b0) begin
      errors++; $display("FAIL full_lower subir got=%b exp=0", subir2);
    end
    step();
    checks++; if ({subir2, conc_ent2} !== 2'b11) begin
      errors++; $display("FAIL full_held_entry got=%b exp=11", {subir2, conc_ent2});
    end
  endtask

  task automatic serve_check(input logic exp_ent, input int idx);
    checks++; if ({subir, conc_ent, conc_sal} !== {1'b1, exp_ent, !exp_ent}) begin
      errors++; $display("FAIL arb_grant%0d got=%b exp=%b", idx, {subir, conc_ent, conc_sal}, {1'b1, exp_ent, !exp_ent});
    end
    tope = 1'b1; step();
    if (exp_ent) entrada = 1'b1; else salida = 1'b1;
    step();
    entrada = 1'b0; salida = 1'b0; tope = 1'b0;
    repeat (20) step();
  endtask

  task automatic test_arbitration();
    logic first;
`ifdef COCHERA_ROUND_ROBIN_EN
    first = 1'b1;
`else
    first = 1'b0;
`endif
    do_reset();
    for (int r = 0; r < 2; r++) begin
      pedido_ent = 1'b1; pedido_sal = 1'b1; step();
      pedido_ent = 1'b0; pedido_sal = 1'b0;
      step();
      serve_check(first, 2 * r);
      step();
      serve_check(!first, 2 * r + 1);
    end
  endtask

  task automatic test_raise_timeout();
    do_reset();
    pedido_ent = 1'b1; step(); pedido_ent = 1'b0;
    step();
    repeat (199) step();
    checks++; if ({subir, err_tope} !== 2'b10) begin
      errors++; $display("FAIL to_before got=%b exp=10", {subir, err_tope});
    end
    step();
    checks++; if ({err_tope, subir, conc_ent, ocupacion} !== {3'b100, 5'd0}) begin
      errors++; $display("FAIL to_fire err=%b subir=%b conc=%b ocup=%0d exp 1 0 0 0", err_tope, subir, conc_ent, ocupacion);
    end
    step();
    checks++; if (err_tope !== 1'b0) begin
      errors++; $display("FAIL to_pulse_len err got=%b exp=0", err_tope);
    end
    repeat (25) step();
    checks++; if (subir !== 1'b0) begin
      errors++; $display("FAIL to_pend_cleared subir got=%b exp=0", subir);
    end
  endtask

  task automatic test_counter_edges();
    do_reset();
    salida = 1'b1; step(); salida = 1'b0;
    checks++; if (ocupacion !== 5'd0) begin
      errors++; $display("FAIL cnt_floor got=%0d exp=0", ocupacion);
    end
    entrada = 1'b1; repeat (5) step(); entrada = 1'b0;
    checks++; if (ocupacion !== 5'd5) begin
      errors++; $display("FAIL cnt_five got=%0d exp=5", ocupacion);
    end
    entrada = 1'b1; salida = 1'b1; step(); entrada = 1'b0; salida = 1'b0;
    checks++; if (ocupacion !== 5'd5) begin
      errors++; $display("FAIL cnt_both got=%0d exp=5", ocupacion);
    end
    checks++; if ({ocupacion2, lleno2} !== {5'd2, 1'b1}) begin
      errors++; $display("FAIL cnt_cap2 ocup=%0d lleno=%b exp 2 1", ocupacion2, lleno2);
    end
    entrada = 1'b1; repeat (11) step();
    checks++; if ({ocupacion, lleno} !== {5'd16, 1'b1}) begin
      errors++; $display("FAIL cnt_full ocup=%0d lleno=%b exp 16 1", ocupacion, lleno);
    end
    step(); entrada = 1'b0;
    checks++; if (ocupacion !== 5'd16) begin
      errors++; $display("FAIL cnt_ceiling got=%0d exp=16", ocupacion);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    entrada = 1'b1; step(); entrada = 1'b0;
    pedido_ent = 1'b1; step(); pedido_ent = 1'b0;
    step();
    tope = 1'b1; step();
    pedido_sal = 1'b1; step(); pedido_sal = 1'b0;
    checks++; if ({subir, conc_ent, ocupacion} !== {2'b11, 5'd1}) begin
      errors++; $display("FAIL ar_pre subir=%b conc=%b ocup=%0d exp 1 1 1", subir, conc_ent, ocupacion);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({subir, conc_ent, conc_sal, ocupacion} !== {3'b000, 5'd0}) begin
      errors++; $display("FAIL ar_async subir=%b ce=%b cs=%b ocup=%0d exp 0 0 0 0", subir, conc_ent, conc_sal, ocupacion);
    end
    tope = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) step();
    checks++; if ({subir, conc_ent, conc_sal} !== 3'b000) begin
      errors++; $display("FAIL ar_requests_gone got=%b exp=000", {subir, conc_ent, conc_sal});
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_full_lot();
    test_arbitration();
    test_raise_timeout();
    test_counter_edges();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_cochera.md
# control_cochera

Parking-lot access controller that sits above the two-sensor passage FSM (`fsm_estacionamiento`). It shares one motorised barrier between an entry lane and an exit lane, and sequences the barrier through raise, open, lower and timeout. It keeps the occupancy count from the FSM's `entrada`/`salida` pulses and blocks new entries when the lot is full.

## Interface
- `CAPACIDAD`, default 16: number of spaces; valid range 1..(2^W_CNT − 1).
- `W_CNT`, default 5: width of the occupancy counter.
- `T_MAX`, default 200: cycles allowed in RAISE or OPEN before timeout.
- `T_BAJADA`, default 20: fixed cycles spent in LOWER.
- Counter width for the timers: wide enough for max(T_MAX, T_BAJADA).

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pedido_ent` in 1: entry reader request, 1-cycle pulse.
- `pedido_sal` in 1: exit reader request, 1-cycle pulse.
- `entrada` in 1: passage FSM, car entered, 1-cycle pulse.
- `salida` in 1: passage FSM, car left, 1-cycle pulse.
- `tope` in 1: barrier fully-up limit switch, level, already synchronised.
- `subir` out 1: barrier motor raise command; barrier falls when low.
- `conc_ent` out 1: entry lane currently granted.
- `conc_sal` out 1: exit lane currently granted.
- `ocupacion` out W_CNT: cars inside.
- `lleno` out 1: `ocupacion == CAPACIDAD`.
- `err_tope` out 1: 1-cycle pulse when RAISE times out.

## Operation
- **Pending latches** `pend_ent` and `pend_sal`.
  - Set on the request pulse.
  - Cleared when that lane is granted, i.e. on the IDLE→RAISE transition.
  - A request arriving while its latch is already set is absorbed.
- **States:** IDLE, RAISE, OPEN, LOWER.
- **IDLE:** `subir=0`, no grant. Grant eligibility:
  - Exit lane is eligible when `pend_sal` is set.
  - Entry lane is eligible when `pend_ent` is set and `!lleno`.
  - Entry stays pending, not dropped, while `lleno` is high.
- **Arbitration when both lanes are eligible:** see Configuration. The granted lane's `conc_*` is set and the block goes to RAISE.
- **RAISE:** `subir=1`.
  - `tope=1` → OPEN, timer cleared.
  - Timer reaching T_MAX → pulse `err_tope`, go to LOWER.
- **OPEN:** `subir=1`.
  - The matching passage pulse (`entrada` with `conc_ent`, or `salida` with `conc_sal`) → LOWER.
  - Timer reaching T_MAX → LOWER, with no error.
- **LOWER:** `subir=0`, grant cleared. After T_BAJADA cycles → IDLE.
- **Occupancy:**
  - Updated on every `entrada`/`salida` pulse, regardless of state; the passage FSM is authoritative.
  - `entrada` alone → +1, saturating at CAPACIDAD.
  - `salida` alone → −1, saturating at 0.
  - Both in the same cycle → unchanged.

## Timing
- **Reset values:** all outputs 0, `ocupacion=0`, state IDLE, pending latches 0, round-robin pointer set to favour entry first.
- **Reset mid-operation:** asserting `reset_n` low in any state drops `subir` immediately (asynchronously) and discards pending requests.
- **All outputs are registered.** `lleno` is derived from the registered count, so it updates the same edge as `ocupacion`.
- **Request to motor latency:** a request pulse at edge N latches `pend_*` at N. From IDLE, grant and `subir=1` take effect at N+1.
- **Raise to open:** `tope` sampled high at edge M gives OPEN from M; `subir` stays high continuously.
- **Passage pulse at edge P:** state LOWER and `subir=0` from P. `ocupacion` is updated at P. IDLE is reached at P+T_BAJADA.
- **Requests during RAISE/OPEN/LOWER** are latched and served after returning to IDLE.
- **Timer boundaries:**
  - RAISE timeout fires when the timer equals T_MAX−1 at the clock edge, so the block spends exactly T_MAX cycles in RAISE.
  - OPEN timeout uses the same rule.
  - LOWER lasts exactly T_BAJADA cycles.
- **`err_tope`** is high for exactly the cycle in which LOWER is entered from RAISE.

## Configuration
- Macro: `COCHERA_ROUND_ROBIN_EN`.
- **Defined:** when both lanes are eligible in IDLE, grant the lane not served last. The pointer updates on every grant. After reset, entry wins the first tie.
- **Undefined:** fixed priority to the exit lane, which frees spaces first. The pointer logic is removed.

## Test plan
- **Entry cycle:** reset; `pedido_ent`; `tope=1` 3 cycles after `subir`; `entrada` pulse → `subir` drops on the pulse edge, `ocupacion=1`, IDLE reached after 20 more cycles.
- **Full lot:** CAPACIDAD=2, two complete entries, then `pedido_ent` → `lleno=1`, `subir` stays 0. Then `pedido_sal` → exit served. After `salida`, `ocupacion=1`, `lleno=0`, and the held entry is then granted.
- **Simultaneous requests with macro defined:** both requests in the same cycle, twice → grants ent, sal, then ent, sal. Without the macro → sal granted first both times.
- **Raise timeout:** `pedido_ent`, keep `tope=0` → `err_tope` pulses after 200 cycles in RAISE, `subir=0`, `ocupacion` unchanged, entry pending cleared.
- **Counter edges:**
  - `salida` at `ocupacion=0` → stays 0.
  - `entrada` and `salida` in the same cycle at `ocupacion=5` → stays 5.
  - `entrada` at CAPACIDAD → stays at CAPACIDAD.
- **Async reset:** `reset_n` low mid-OPEN → `subir`, `conc_*` and `ocupacion` go to 0 without waiting for a clock edge. After release, the block sits in IDLE and previous requests are gone.
